cnn_train_sequencer: RTL and testbench

//  Parametrised training/inference sequencer for the conv->maxpool->flatten->FCL->softmax->CE datapath.

---
 rtl/cnn_train_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_cnn_train_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_train_sequencer.sv
// cnn_train_sequencer: seeds conv kernels and FCL weight rows from per-lane LFSRs,
// then sequences load -> settle -> softmax -> optional commit for one sample per handshake.
module cnn_train_sequencer #(
   parameter int unsigned  WIDTH          = 32,
   parameter int unsigned  CHANNELS       = 10,
   parameter int unsigned  KERNEL_DIM     = 3,
   parameter int unsigned  FCL_INPUT_DIM  = 1690,
   parameter int unsigned  FCL_OUTPUT_DIM = 10,
   parameter int unsigned  INIT_SHIFT     = 4,
   parameter int unsigned  SETTLE_CYCLES  = 2,
   parameter int unsigned  TIMEOUT        = 1024,
   parameter logic [31:0]  LFSR_SEED      = 32'hACE1_2468,
   localparam int unsigned K2             = KERNEL_DIM * KERNEL_DIM,
   localparam int unsigned CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned ROW_W          = $clog2(FCL_INPUT_DIM + 1) + 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              sample_valid,
   output logic                              sample_ready,
   input  logic                              train_mode,
   input  logic                              reinit,
   output logic                              sample_load,
   output logic                              softmax_start,
   input  logic                              softmax_done,
   output logic                              commit,
   output logic                              kern_we,
   output logic [CH_W-1:0]                   kern_ch,
   output logic [K2*WIDTH-1:0]               kern_data,
   output logic                              fcl_we,
   output logic [ROW_W-1:0]                  fcl_row,
   output logic [FCL_OUTPUT_DIM*WIDTH-1:0]   fcl_data,
   output logic                              init_done,
   output logic [31:0]                       sample_count,
   output logic                              timeout_err
);

   localparam int unsigned LANES   = (K2 > FCL_OUTPUT_DIM) ? K2 : FCL_OUTPUT_DIM;
   localparam int unsigned IDX_W   = (ROW_W > CH_W) ? ROW_W : CH_W;
   localparam int unsigned CNT_MAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [31:0] POLY    = 32'h8020_0003;
   localparam logic [31:0] GOLDEN  = 32'h9E37_79B9;

   typedef enum logic [2:0] {
      S_INIT_KERN,
      S_INIT_FCL,
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_START,
      S_WAIT,
      S_COMMIT
   } state_t;

   // Per-lane seed; a zero seed would lock the LFSR, so it is forced to 1.
   function automatic logic [31:0] lane_seed(input int unsigned i);
      logic [31:0] s;
      s = LFSR_SEED ^ (32'(i) * GOLDEN);
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

   // One Galois step, shifting right with feedback from bit 0.
   function automatic logic [31:0] lane_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
   endfunction

   // Low WIDTH bits of a lane, sign-preserving scaled down by INIT_SHIFT.
   function automatic logic [WIDTH-1:0] init_word(input logic [31:0] s);
      logic signed [WIDTH-1:0] w;
      w = signed'(s[WIDTH-1:0]);
      return WIDTH'(w >>> INIT_SHIFT);
   endfunction

   state_t                          state_q, state_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [31:0]                     lane_q [LANES];
   logic                            train_q;
   logic                            sample_ready_q, init_done_q, sample_load_q;
   logic                            softmax_start_q, commit_q, timeout_err_q;
   logic                            kern_we_q, fcl_we_q;
   logic [CH_W-1:0]                 kern_ch_q;
   logic [ROW_W-1:0]                fcl_row_q;
   logic [K2*WIDTH-1:0]             kern_data_q, kern_word_c;
   logic [FCL_OUTPUT_DIM*WIDTH-1:0] fcl_data_q, fcl_word_c;
   logic [31:0]                     sample_count_q;
   logic                            init_step_c, accept_c, done_hit_c, tmo_hit_c;

   // Event decode and shaped init words from the current (pre-step) lanes.
   always_comb begin
      kern_word_c = '0;
      fcl_word_c  = '0;
      for (int unsigned k = 0; k < K2; k++)
         kern_word_c[k*WIDTH +: WIDTH] = init_word(lane_q[k]);
      for (int unsigned j = 0; j < FCL_OUTPUT_DIM; j++)
         fcl_word_c[j*WIDTH +: WIDTH] = init_word(lane_q[j]);
      init_step_c = (state_q == S_INIT_KERN) || (state_q == S_INIT_FCL);
      accept_c    = (state_q == S_IDLE) && !reinit && sample_valid && sample_ready_q;
      done_hit_c  = (state_q == S_WAIT) && softmax_done;
      tmo_hit_c   = (state_q == S_WAIT) && !softmax_done && (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   // Next-state logic; done has priority over the watchdog on the last WAIT cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_INIT_KERN: begin
            if (idx_q == IDX_W'(CHANNELS - 1)) begin
               state_d = S_INIT_FCL;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_INIT_FCL: begin
            if (idx_q == IDX_W'(FCL_INPUT_DIM)) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_IDLE: begin
            if (reinit)        state_d = S_INIT_KERN;
            else if (accept_c) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_SETTLE;
            cnt_d   = '0;
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = S_START;
            else                                    cnt_d   = cnt_q + CNT_W'(1);
         end
         S_START: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            if (done_hit_c)     state_d = train_q ? S_COMMIT : S_IDLE;
            else if (tmo_hit_c) state_d = S_IDLE;
            else                cnt_d   = cnt_q + CNT_W'(1);
         end
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_INIT_KERN;
      endcase
   end

   // State, LFSR lanes and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_INIT_KERN;
         idx_q           <= '0;
         cnt_q           <= '0;
         train_q         <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= lane_seed(i);
         sample_ready_q  <= 1'b0;
         init_done_q     <= 1'b0;
         sample_load_q   <= 1'b0;
         softmax_start_q <= 1'b0;
         commit_q        <= 1'b0;
         timeout_err_q   <= 1'b0;
         kern_we_q       <= 1'b0;
         kern_ch_q       <= '0;
         kern_data_q     <= '0;
         fcl_we_q        <= 1'b0;
         fcl_row_q       <= '0;
         fcl_data_q      <= '0;
         sample_count_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         if (init_step_c)
            for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= lane_step(lane_q[i]);
         if (accept_c) train_q <= train_mode;
         sample_ready_q  <= (state_q == S_IDLE) && (state_d == S_IDLE);
         init_done_q     <= !init_step_c && (state_d != S_INIT_KERN);
         sample_load_q   <= (state_d == S_LOAD);
         softmax_start_q <= (state_d == S_START);
         commit_q        <= (state_d == S_COMMIT);
         kern_we_q       <= (state_q == S_INIT_KERN);
         fcl_we_q        <= (state_q == S_INIT_FCL);
         if (state_q == S_INIT_KERN) begin
            kern_ch_q   <= CH_W'(idx_q);
            kern_data_q <= kern_word_c;
         end
         if (state_q == S_INIT_FCL) begin
            fcl_row_q  <= ROW_W'(idx_q);
            fcl_data_q <= fcl_word_c;
         end
         if (done_hit_c) sample_count_q <= sample_count_q + 32'd1;
         if (tmo_hit_c)  timeout_err_q  <= 1'b1;
      end
   end

   assign sample_ready  = sample_ready_q;
   assign init_done     = init_done_q;
   assign sample_load   = sample_load_q;
   assign softmax_start = softmax_start_q;
   assign commit        = commit_q;
   assign timeout_err   = timeout_err_q;
   assign kern_we       = kern_we_q;
   assign kern_ch       = kern_ch_q;
   assign kern_data     = kern_data_q;
   assign fcl_we        = fcl_we_q;
   assign fcl_row       = fcl_row_q;
   assign fcl_data      = fcl_data_q;
   assign sample_count  = sample_count_q;

endmodule

// File: tb/tb_cnn_train_sequencer.sv
// tb_cnn_train_sequencer: randomized sample traffic against a cycle-position reference
// model, plus an LFSR init-stream model for the kernel and FCL seeding writes.
module tb_cnn_train_sequencer;

   localparam int unsigned WIDTH          = 32;
   localparam int unsigned CHANNELS       = 10;
   localparam int unsigned KERNEL_DIM     = 3;
   localparam int unsigned FCL_INPUT_DIM  = 1690;
   localparam int unsigned FCL_OUTPUT_DIM = 10;
   localparam int unsigned INIT_SHIFT     = 4;
   localparam int unsigned SETTLE_CYCLES  = 2;
   localparam int unsigned TIMEOUT        = 16;
   localparam logic [31:0] LFSR_SEED      = 32'hACE1_2468;
   localparam int unsigned K2             = KERNEL_DIM * KERNEL_DIM;
   localparam int unsigned LANES          = (K2 > FCL_OUTPUT_DIM) ? K2 : FCL_OUTPUT_DIM;
   localparam int unsigned CH_W           = $clog2(CHANNELS);
   localparam int unsigned ROW_W          = $clog2(FCL_INPUT_DIM + 1) + 1;

   logic                            clk;
   logic                            reset;
   logic                            sample_valid;
   logic                            sample_ready;
   logic                            train_mode;
   logic                            reinit;
   logic                            sample_load;
   logic                            softmax_start;
   logic                            softmax_done;
   logic                            commit;
   logic                            kern_we;
   logic [CH_W-1:0]                 kern_ch;
   logic [K2*WIDTH-1:0]             kern_data;
   logic                            fcl_we;
   logic [ROW_W-1:0]                fcl_row;
   logic [FCL_OUTPUT_DIM*WIDTH-1:0] fcl_data;
   logic                            init_done;
   logic [31:0]                     sample_count;
   logic                            timeout_err;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_lane [LANES];
   logic [31:0] m_count;
   logic        m_err;

   cnn_train_sequencer #(
      .WIDTH(WIDTH), .CHANNELS(CHANNELS), .KERNEL_DIM(KERNEL_DIM),
      .FCL_INPUT_DIM(FCL_INPUT_DIM), .FCL_OUTPUT_DIM(FCL_OUTPUT_DIM),
      .INIT_SHIFT(INIT_SHIFT), .SETTLE_CYCLES(SETTLE_CYCLES),
      .TIMEOUT(TIMEOUT), .LFSR_SEED(LFSR_SEED)
   ) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .train_mode(train_mode), .reinit(reinit), .sample_load(sample_load),
      .softmax_start(softmax_start), .softmax_done(softmax_done), .commit(commit),
      .kern_we(kern_we), .kern_ch(kern_ch), .kern_data(kern_data),
      .fcl_we(fcl_we), .fcl_row(fcl_row), .fcl_data(fcl_data),
      .init_done(init_done), .sample_count(sample_count), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference LFSR lanes, per the seeding rules.
   function automatic logic [31:0] m_seed(input int unsigned i);
      logic [31:0] s;
      s = LFSR_SEED ^ (32'(i) * 32'h9E37_79B9);
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

   function automatic logic [31:0] m_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   function automatic logic [WIDTH-1:0] m_word(input logic [31:0] s);
      logic signed [WIDTH-1:0] w;
      w = signed'(s[WIDTH-1:0]);
      return WIDTH'(w >>> INIT_SHIFT);
   endfunction

   task automatic m_reseed();
      for (int unsigned i = 0; i < LANES; i++) m_lane[i] = m_seed(i);
   endtask

   task automatic m_advance();
      for (int unsigned i = 0; i < LANES; i++) m_lane[i] = m_next(m_lane[i]);
   endtask

   task automatic do_reset();
      reset = 1'b1; sample_valid = 1'b0; reinit = 1'b0; softmax_done = 1'b0; train_mode = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", sample_ready, 0);
      check("rst_init_done", init_done, 0);
      check("rst_kern_we", kern_we, 0);
      check("rst_fcl_we", fcl_we, 0);
      check("rst_load", sample_load, 0);
      check("rst_start", softmax_start, 0);
      check("rst_commit", commit, 0);
      check("rst_count", sample_count, 0);
      check("rst_timeout", timeout_err, 0);
      reset = 1'b0;
      m_reseed();
      m_count = 32'd0;
      m_err   = 1'b0;
   endtask

   // Follow one full init stream and compare every write with the lane model.
   task automatic run_init(output logic [K2*WIDTH-1:0] first_k);
      int nk, nf, budget, n_load, n_commit, bad_done;
      logic [K2*WIDTH-1:0]             ek;
      logic [FCL_OUTPUT_DIM*WIDTH-1:0] ef;
      nk = 0; nf = 0; budget = 0; n_load = 0; n_commit = 0; bad_done = 0;
      first_k = '0;
      while (nf < int'(FCL_INPUT_DIM + 1) && budget < 4000) begin
         @(negedge clk);
         budget++;
         if (sample_load) n_load++;
         if (commit) n_commit++;
         if (init_done) bad_done++;
         if (kern_we && fcl_we) check("we_exclusive", 1, 0);
         if (kern_we) begin
            for (int unsigned k = 0; k < K2; k++) ek[k*WIDTH +: WIDTH] = m_word(m_lane[k]);
            check("kern_order", nf, 0);
            check("kern_ch", kern_ch, nk);
            check("kern_data", kern_data, ek);
            if (nk == 0) first_k = kern_data;
            nk++;
            m_advance();
         end else if (fcl_we) begin
            for (int unsigned j = 0; j < FCL_OUTPUT_DIM; j++) ef[j*WIDTH +: WIDTH] = m_word(m_lane[j]);
            if (nf == 0) check("fcl_after_kern", nk, CHANNELS);
            check("fcl_row", fcl_row, nf);
            check("fcl_data", fcl_data, ef);
            nf++;
            m_advance();
         end
      end
      check("kern_count", nk, CHANNELS);
      check("fcl_count", nf, FCL_INPUT_DIM + 1);
      check("init_done_low", bad_done, 0);
      @(negedge clk);
      check("init_done_high", init_done, 1);
      check("init_extra_we", kern_we | fcl_we, 0);
      check("init_no_load", n_load, 0);
      check("init_no_commit", n_commit, 0);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!sample_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", sample_ready, 1);
   endtask

   // One sample; expected event positions are cycles counted from the accept edge.
   task automatic run_sample(input bit train, input int delay, input bit to);
      int start_at, done_at, idle_at, commit_at;
      int n_load, n_start, n_commit, f_load, f_start, f_commit, bad_ready;
      bit busy;
      logic [31:0] exp_count;
      wait_ready();
      sample_valid = 1'b1;
      train_mode   = train;
      start_at  = 2 + SETTLE_CYCLES;
      done_at   = to ? -100 : start_at + delay;
      idle_at   = to ? start_at + TIMEOUT + 1 : (train ? done_at + 2 : done_at + 1);
      commit_at = (!to && train) ? done_at + 1 : -1;
      exp_count = to ? m_count : m_count + 32'd1;
      n_load = 0; n_start = 0; n_commit = 0; f_load = 0; f_start = 0; f_commit = 0; bad_ready = 0;
      for (int i = 1; i <= idle_at + 2; i++) begin
         @(negedge clk);
         if (sample_load) begin n_load++; if (f_load == 0) f_load = i; end
         if (softmax_start) begin n_start++; if (f_start == 0) f_start = i; end
         if (commit) begin n_commit++; if (f_commit == 0) f_commit = i; end
         if (sample_ready != (i > idle_at)) bad_ready++;
         if (to && i == idle_at - 1) check("tmo_before", timeout_err, m_err);
         if (to && i == idle_at) check("tmo_set", timeout_err, 1);
         if (!to && i == done_at + 1) check("count_step", sample_count, exp_count);
         busy = (i < idle_at);
         softmax_done = (i == done_at) || (i == start_at && $urandom_range(0, 1) == 1);
         sample_valid = busy ? 1'($urandom_range(0, 1)) : 1'b0;
         reinit       = busy ? 1'($urandom_range(0, 1)) : 1'b0;
         train_mode   = 1'($urandom_range(0, 1));
      end
      softmax_done = 1'b0;
      check("load_at", f_load, 1);
      check("load_n", n_load, 1);
      check("start_at", f_start, start_at);
      check("start_n", n_start, 1);
      check("commit_n", n_commit, (commit_at > 0) ? 1 : 0);
      if (commit_at > 0) check("commit_at", f_commit, commit_at);
      check("ready_trace", bad_ready, 0);
      check("count", sample_count, exp_count);
      if (to) m_err = 1'b1;
      check("timeout_err", timeout_err, m_err);
      m_count = exp_count;
   endtask

   initial begin
      logic [K2*WIDTH-1:0] first_k, again_k, dummy_k;
      int n_commit;
      reset = 1'b1; sample_valid = 1'b0; train_mode = 1'b0; reinit = 1'b0; softmax_done = 1'b0;

      do_reset();
      run_init(first_k);
      check("kern_word0", first_k[31:0], 32'hFACE_1246);

      run_sample(1'b1, 5, 1'b0);
      run_sample(1'b0, 5, 1'b0);
      run_sample(1'b1, 0, 1'b1);
      run_sample(1'b1, TIMEOUT, 1'b0);
      for (int n = 0; n < 12; n++)
         run_sample(1'($urandom_range(0, 1)), int'($urandom_range(1, TIMEOUT)),
                    $urandom_range(0, 4) == 0);

      // reinit and sample_valid together: reinit wins, lanes continue without reseed
      wait_ready();
      sample_valid = 1'b1; reinit = 1'b1; train_mode = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0; reinit = 1'b0;
      check("reinit_ready", sample_ready, 0);
      check("reinit_done", init_done, 0);
      run_init(dummy_k);
      run_sample(1'b1, 3, 1'b0);

      // reset while waiting for softmax: no commit, init restarts from seeds
      wait_ready();
      sample_valid = 1'b1; train_mode = 1'b1;
      n_commit = 0;
      for (int i = 1; i <= int'(SETTLE_CYCLES) + 5; i++) begin
         @(negedge clk);
         sample_valid = 1'b0;
         if (commit) n_commit++;
      end
      reset = 1'b1;
      @(negedge clk);
      if (commit) n_commit++;
      do_reset();
      check("rst_wait_commit", n_commit, 0);
      run_init(again_k);
      check("rerun_same", again_k, first_k);
      run_sample(1'b0, 7, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
